// File: rtl/pipelined_addsub_seg.sv
// rtl/pipelined_addsub_seg.sv - segmented, pipelined WIDTH-bit adder/subtractor with valid/ready flow control
module pipelined_addsub_seg #(
    parameter int WIDTH = 128,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_addsub_seg: WIDTH must be a positive multiple of SEG");
    end

    // Stage k register holds a word that is rotated right by SEG every stage:
    // resolved sum segments enter at the top, unresolved operand-A segments
    // drain out of the bottom. After STAGES stages it is exactly the sum.
    // The B word just shifts right, so its low segment is always the next one
    // to be added.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_d;
    logic              ovf_d;

    logic advance;

    // The whole pipe moves together; only a held result at the output blocks it.
    assign advance   = ~v_q[STAGES-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign s         = a_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic             c_src;
        logic             v_src;
        logic [SEG:0]     seg_sum;

        if (k == 0) begin : g_first
            // Stage 0 works straight off the live inputs; subtract inverts B only.
            assign a_src = a;
            assign b_src = b ^ {WIDTH{sub}};
            assign c_src = cin;
            assign v_src = in_valid;
        end else begin : g_next
            assign a_src = a_q[k-1];
            assign b_src = b_q[k-1];
            assign c_src = c_q[k-1];
            assign v_src = v_q[k-1];
        end

        assign seg_sum = {1'b0, a_src[SEG-1:0]} + {1'b0, b_src[SEG-1:0]} + {{SEG{1'b0}}, c_src};
        assign a_d[k]  = (WIDTH'(seg_sum[SEG-1:0]) << (WIDTH - SEG)) | (a_src >> SEG);
        assign b_d[k]  = b_src >> SEG;
        assign c_d[k]  = seg_sum[SEG];
        assign v_d[k]  = v_src;

        if (k == STAGES - 1) begin : g_last
            // Signed overflow: operands agree in sign but the result does not,
            // which is the same as carry-into-MSB differing from carry-out.
            assign ovf_d = (a_src[SEG-1] == b_src[SEG-1]) && (seg_sum[SEG-1] != a_src[SEG-1]);
        end
    end

    // Advance every stage register together; reset clears valids and the visible result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q              <= '0;
            a_q[STAGES-1]    <= '0;
            c_q[STAGES-1]    <= 1'b0;
            ovf_q            <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub_seg.sv
// tb/tb_pipelined_addsub_seg.sv - scoreboard bench for pipelined_addsub_seg
module tb_pipelined_addsub_seg;

    localparam int W   = 128;
    localparam int SEG = 16;
    localparam int ST  = W / SEG;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    pipelined_addsub_seg #(.WIDTH(W), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   retire_cyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_retire = 0;
    int   n_flush = 0;
    int   last_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned and sign-extended arithmetic.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic sv);
        exp_t         r;
        logic [W-1:0] be;
        logic [W:0]   ux;
        logic [W+1:0] sx;
        be     = sv ? ~bv : bv;
        ux     = {1'b0, av} + {1'b0, be} + (W+1)'(cv);
        sx     = {{2{av[W-1]}}, av} + {{2{be[W-1]}}, be} + (W+2)'(cv);
        r.s    = ux[W-1:0];
        r.cout = ux[W];
        r.ovf  = sx[W] ^ sx[W-1];
        r.cyc  = 0;
        return r;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] sv, input logic cv, input logic ov);
        exp_t r;
        r.s = sv; r.cout = cv; r.ovf = ov; r.cyc = 0;
        return r;
    endfunction

    // Monitor: every retiring result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got s=%h with empty scoreboard", s);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result_s", s, e.s);
                check("result_cout", W'(cout), W'(e.cout));
                check("result_ovf", W'(ovf), W'(e.ovf));
                last_lat = cyc - e.cyc;
                n_retire++;
                retire_cyc.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic sv,
                        input bit dir, input exp_t de);
        exp_t e;
        bit   done;
        done = 1'b0;
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        e = dir ? de : model(av, bv, cv, sv);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                e.cyc = cyc;
                sbq.push_back(e);
                n_push++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=%b expected 1 within 200 cycles", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        exp_t         dummy;
        av = {$urandom, $urandom, $urandom, $urandom};
        bv = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: av = '1;
            1: bv = '1;
            2: av = {1'b1, {(W-1){1'b0}}};
            3: av = {1'b0, {(W-1){1'b1}}};
            default: ;
        endcase
        dummy = mk('0, 1'b0, 1'b0);
        send(av, bv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, dummy);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(posedge clk);
            if (sbq.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sbq.size());
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t d;
        bit   seen;
        bit   rnd_done;
        int   nq;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

        // 1: reset state and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_s", s, '0);
        check("reset_cout", W'(cout), W'(0));
        check("reset_ovf", W'(ovf), W'(0));
        check("reset_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_out_valid", W'(out_valid), W'(0));
        end
        @(posedge clk);
        #1;

        // 2: full ripple across every segment, with latency
        d = mk('0, 1'b1, 1'b0);
        send('1, '0, 1'b1, 1'b0, 1'b1, d);
        drain();
        check("ripple_latency", W'(last_lat), W'(ST));

        // 5: directed subtract and signed overflow
        d = mk({W{1'b1}} - W'(1), 1'b0, 1'b0);
        send(W'(5), W'(7), 1'b1, 1'b1, 1'b1, d);
        d = mk({1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
        send({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, 1'b1, d);
        drain();

        // 3: 50 back-to-back random ops at full rate
        retire_cyc.delete();
        for (int i = 0; i < 50; i++) send_rand();
        drain();
        check("stream_count", W'(retire_cyc.size()), W'(50));
        if (retire_cyc.size() == 50)
            check("stream_rate", W'(retire_cyc[49] - retire_cyc[0]), W'(49));

        // 4: stall a full pipe for 3 cycles
        fork
            begin
                for (int i = 0; i < 20; i++) send_rand();
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 100 && !seen; t++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1) seen = 1'b1;
                end
                check("stall_output_reached", W'(seen), W'(1));
                @(posedge clk);
                #1 out_ready = 1'b0;
                for (int t = 0; t < 3; t++) begin
                    @(negedge clk);
                    check("stall_in_ready", W'(in_ready), W'(0));
                    check("stall_out_valid", W'(out_valid), W'(1));
                    if (sbq.size() > 0) check("stall_s_held", s, sbq[0].s);
                    else check("stall_queue_depth", W'(sbq.size()), W'(1));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // random bubbles with random back-pressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // 6: reset with 4 ops in flight discards them
        for (int i = 0; i < 4; i++) send_rand();
        rst_n = 1'b0;
        nq = sbq.size();
        check("flush_inflight_count", W'(nq), W'(4));
        n_flush += nq;
        sbq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("flush_out_valid", W'(out_valid), W'(0));
        check("flush_s", s, '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("flush_idle_out_valid", W'(out_valid), W'(0));
        end

        check("total_retired", W'(n_retire), W'(n_push - n_flush));
        check("scoreboard_empty", W'(sbq.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
